// File: rtl/loader_pkg.sv
// Shared types for the program loader: FSM state encoding, default sizes and
// the state-to-output decode used to register the loader's status outputs.
package loader_pkg;

    localparam int ADDR_W_DEF    = 7;
    localparam int DATA_W_DEF    = 16;
    localparam int MAX_WORDS_DEF = 128;

    typedef enum logic [3:0] {
        IDLE    = 4'd0,
        LEN_HI  = 4'd1,
        LEN_LO  = 4'd2,
        DATA_HI = 4'd3,
        DATA_LO = 4'd4,
        WRITE   = 4'd5,
        CHECK   = 4'd6,
        DONE    = 4'd7,
        ERROR   = 4'd8
    } state_t;

    typedef struct packed {
        logic in_ready;
        logic mem_wr;
        logic busy;
        logic done;
        logic error;
        logic proc_reset;
    } flags_t;

    // The processor is held in reset everywhere except after a good image.
    function automatic flags_t state_flags(input state_t st);
        flags_t f;
        f = '0;
        case (st)
            IDLE: begin
                f.proc_reset = 1'b1;
            end
            LEN_HI, LEN_LO, DATA_HI, DATA_LO, CHECK: begin
                f.in_ready   = 1'b1;
                f.busy       = 1'b1;
                f.proc_reset = 1'b1;
            end
            WRITE: begin
                f.mem_wr     = 1'b1;
                f.busy       = 1'b1;
                f.proc_reset = 1'b1;
            end
            DONE: begin
                f.done = 1'b1;
            end
            ERROR: begin
                f.error      = 1'b1;
                f.proc_reset = 1'b1;
            end
            default: begin
                f.proc_reset = 1'b1;
            end
        endcase
        return f;
    endfunction

endpackage

// File: rtl/byte_pair_assembler.sv
// Collects two big-endian bytes into a 16-bit register; hi_sel_i picks which
// half the accepted byte lands in.
module byte_pair_assembler (
    input  logic        clock_i,
    input  logic        reset_i,
    input  logic [7:0]  byte_i,
    input  logic        load_i,
    input  logic        hi_sel_i,
    output logic [15:0] word_o
);

    logic [15:0] word_q;

    // Capture the accepted byte into the selected half of the word.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            word_q <= 16'h0000;
        end else if (load_i) begin
            if (hi_sel_i) begin
                word_q[15:8] <= byte_i;
            end else begin
                word_q[7:0] <= byte_i;
            end
        end else begin
            word_q <= word_q;
        end
    end

    assign word_o = word_q;

endmodule

// File: rtl/program_loader.sv
// Byte-stream instruction image loader; holds the processor in reset until a
// complete image is written. Define LOADER_CHECKSUM_EN for a trailing XOR byte.
module program_loader
    import loader_pkg::*;
#(
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int DATA_W    = DATA_W_DEF,
    parameter int MAX_WORDS = MAX_WORDS_DEF
) (
    input  logic              clock_i,
    input  logic              reset_i,
    input  logic              start_i,
    input  logic [7:0]        in_data_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_data_o,
    output logic              mem_wr_o,
    output logic              proc_reset_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              error_o,
    output logic [ADDR_W:0]   word_count_o
);

    state_t            state_q, state_d;
    flags_t            flags_q;
    logic [ADDR_W-1:0] index_q, index_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              xfer_s;
    logic              session_start_s;
    logic              len_hi_ld_s, len_lo_ld_s;
    logic              dat_hi_ld_s, dat_lo_ld_s;
    logic [15:0]       len_word_s;
    logic [15:0]       len_full_s;
    logic [15:0]       data_word_s;

    assign xfer_s     = in_valid_i & flags_q.in_ready;
    // The low length byte is judged as it arrives, before it is registered.
    assign len_full_s = {len_word_s[15:8], in_data_i};

`ifdef LOADER_CHECKSUM_EN
    logic [7:0] csum_q, csum_d;

    // Running XOR over payload bytes only; the length field is excluded.
    always_comb begin
        csum_d = csum_q;
        if (session_start_s) begin
            csum_d = 8'h00;
        end else if (dat_hi_ld_s || dat_lo_ld_s) begin
            csum_d = csum_q ^ in_data_i;
        end else begin
            csum_d = csum_q;
        end
    end

    // Checksum register.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            csum_q <= 8'h00;
        end else begin
            csum_q <= csum_d;
        end
    end
`endif

    // Next-state, index and word-count logic.
    always_comb begin
        state_d         = state_q;
        index_d         = index_q;
        count_d         = count_q;
        session_start_s = 1'b0;
        len_hi_ld_s     = 1'b0;
        len_lo_ld_s     = 1'b0;
        dat_hi_ld_s     = 1'b0;
        dat_lo_ld_s     = 1'b0;
        case (state_q)
            IDLE, DONE, ERROR: begin
                if (start_i) begin
                    session_start_s = 1'b1;
                    state_d         = LEN_HI;
                    index_d         = '0;
                    count_d         = '0;
                end else begin
                    state_d = state_q;
                end
            end
            LEN_HI: begin
                if (xfer_s) begin
                    len_hi_ld_s = 1'b1;
                    state_d     = LEN_LO;
                end else begin
                    state_d = state_q;
                end
            end
            LEN_LO: begin
                if (xfer_s) begin
                    len_lo_ld_s = 1'b1;
                    if ((len_full_s == 16'h0000) || (len_full_s > 16'(MAX_WORDS))) begin
                        state_d = ERROR;
                    end else begin
                        state_d = DATA_HI;
                    end
                end else begin
                    state_d = state_q;
                end
            end
            DATA_HI: begin
                if (xfer_s) begin
                    dat_hi_ld_s = 1'b1;
                    state_d     = DATA_LO;
                end else begin
                    state_d = state_q;
                end
            end
            DATA_LO: begin
                if (xfer_s) begin
                    dat_lo_ld_s = 1'b1;
                    state_d     = WRITE;
                end else begin
                    state_d = state_q;
                end
            end
            WRITE: begin
                index_d = index_q + ADDR_W'(1);
                count_d = count_q + (ADDR_W+1)'(1);
                if ((16'(count_q) + 16'd1) == len_word_s) begin
`ifdef LOADER_CHECKSUM_EN
                    state_d = CHECK;
`else
                    state_d = DONE;
`endif
                end else begin
                    state_d = DATA_HI;
                end
            end
`ifdef LOADER_CHECKSUM_EN
            CHECK: begin
                if (xfer_s) begin
                    if (in_data_i == csum_q) begin
                        state_d = DONE;
                    end else begin
                        state_d = ERROR;
                    end
                end else begin
                    state_d = state_q;
                end
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, counters and the registered output flags decoded from next state.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            flags_q <= state_flags(IDLE);
            index_q <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            flags_q <= state_flags(state_d);
            index_q <= index_d;
            count_q <= count_d;
        end
    end

    byte_pair_assembler u_len_asm (
        .clock_i  (clock_i),
        .reset_i  (reset_i),
        .byte_i   (in_data_i),
        .load_i   (len_hi_ld_s | len_lo_ld_s),
        .hi_sel_i (len_hi_ld_s),
        .word_o   (len_word_s)
    );

    byte_pair_assembler u_data_asm (
        .clock_i  (clock_i),
        .reset_i  (reset_i),
        .byte_i   (in_data_i),
        .load_i   (dat_hi_ld_s | dat_lo_ld_s),
        .hi_sel_i (dat_hi_ld_s),
        .word_o   (data_word_s)
    );

    assign in_ready_o   = flags_q.in_ready;
    assign mem_wr_o     = flags_q.mem_wr;
    assign busy_o       = flags_q.busy;
    assign done_o       = flags_q.done;
    assign error_o      = flags_q.error;
    assign proc_reset_o = flags_q.proc_reset;
    assign mem_addr_o   = index_q;
    assign mem_data_o   = data_word_s;
    assign word_count_o = count_q;

endmodule

// File: tb/tb_program_loader.sv
// Scoreboard bench for program_loader: a driver pushes expected RAM writes and
// session outcomes, a negedge monitor pops and compares them.
module tb_program_loader;

    logic        clk = 1'b0;
    logic        reset_i = 1'b1;
    logic        start_i = 1'b0;
    logic [7:0]  in_data_i = 8'h00;
    logic        in_valid_i = 1'b0;
    logic        in_ready_o;
    logic [6:0]  mem_addr_o;
    logic [15:0] mem_data_o;
    logic        mem_wr_o;
    logic        proc_reset_o;
    logic        busy_o;
    logic        done_o;
    logic        error_o;
    logic [7:0]  word_count_o;

    program_loader dut (
        .clock_i      (clk),
        .reset_i      (reset_i),
        .start_i      (start_i),
        .in_data_i    (in_data_i),
        .in_valid_i   (in_valid_i),
        .in_ready_o   (in_ready_o),
        .mem_addr_o   (mem_addr_o),
        .mem_data_o   (mem_data_o),
        .mem_wr_o     (mem_wr_o),
        .proc_reset_o (proc_reset_o),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .error_o      (error_o),
        .word_count_o (word_count_o)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { logic [6:0] addr; logic [15:0] data; } wr_t;
    typedef struct { logic done; int count; } res_t;

    wr_t         exp_wr[$];
    res_t        exp_res[$];
    logic [15:0] fixed_q[$];
    int          checks = 0;
    int          passes = 0;
    int unsigned done_cyc = 0;
    logic        prev_end = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end else begin
            passes++;
        end
    endtask

    // Monitor: every RAM write and every session ending is matched against the scoreboard.
    always @(negedge clk) begin
        if (mem_wr_o) begin
            wr_t w;
            check("wr_in_ready_low", {31'd0, in_ready_o}, 32'd0);
            if (exp_wr.size() == 0) begin
                check("unexpected_write", {25'd0, mem_addr_o}, 32'hFFFF_FFFF);
            end else begin
                w = exp_wr.pop_front();
                check("wr_addr", {25'd0, mem_addr_o}, {25'd0, w.addr});
                check("wr_data", {16'd0, mem_data_o}, {16'd0, w.data});
            end
        end
        if ((done_o | error_o) && !prev_end) begin
            done_cyc <= cyc;
            if (exp_res.size() == 0) begin
                check("unexpected_end", {31'd0, done_o}, 32'hFFFF_FFFF);
            end else begin
                res_t r;
                r = exp_res.pop_front();
                check("end_done", {31'd0, done_o}, {31'd0, r.done});
                check("end_error", {31'd0, error_o}, {31'd0, !r.done});
                check("end_proc_reset", {31'd0, proc_reset_o}, {31'd0, !r.done});
                check("end_word_count", {24'd0, word_count_o}, r.count);
                check("end_busy", {31'd0, busy_o}, 32'd0);
                check("end_pending_writes", exp_wr.size(), 32'd0);
            end
        end
        prev_end <= done_o | error_o;
    end

    // mode: 0 = In_valid held high, 1 = toggling 1,0,1,0, 2 = random.
    task automatic run_session(input int n, input int mode, input bit mid_start,
                               input bit bad_sum, output int latency);
        logic [7:0]  bytes[$];
        logic [15:0] nn;
        logic [15:0] w;
        logic [7:0]  x;
        logic [6:0]  a;
        bit          ok;
        bit          good;
        bit          v;
        int          idx;
        int          budget;
        int unsigned s;
        res_t        r;

        nn = n[15:0];
        ok = (n >= 1) && (n <= 128);
        x  = 8'h00;
        bytes.push_back(nn[15:8]);
        bytes.push_back(nn[7:0]);
        if (ok) begin
            for (int i = 0; i < n; i++) begin
                w = (fixed_q.size() > 0) ? fixed_q.pop_front() : 16'($urandom);
                a = i[6:0];
                bytes.push_back(w[15:8]);
                bytes.push_back(w[7:0]);
                x = x ^ w[15:8] ^ w[7:0];
                exp_wr.push_back('{a, w});
            end
        end
        fixed_q.delete();
`ifdef LOADER_CHECKSUM_EN
        good = ok && !bad_sum;
        if (ok) bytes.push_back(bad_sum ? (x ^ 8'h01) : x);
`else
        good = ok;
`endif
        r.done  = good;
        r.count = ok ? n : 0;
        exp_res.push_back(r);

        @(negedge clk);
        start_i    = 1'b1;
        in_valid_i = 1'b0;
        @(negedge clk);
        start_i = 1'b0;
        s = cyc;
        check("start_busy", {31'd0, busy_o}, 32'd1);
        check("start_done_low", {31'd0, done_o}, 32'd0);
        check("start_error_low", {31'd0, error_o}, 32'd0);
        check("start_proc_reset", {31'd0, proc_reset_o}, 32'd1);
        check("start_word_count", {24'd0, word_count_o}, 32'd0);

        idx    = 0;
        budget = 0;
        while (idx < bytes.size()) begin
            case (mode)
                0:       v = 1'b1;
                1:       v = (budget % 2) == 0;
                default: v = 1'($urandom_range(0, 1));
            endcase
            in_valid_i = v;
            in_data_i  = v ? bytes[idx] : 8'($urandom);
            start_i    = mid_start && (idx == 4);
            if (v && in_ready_o) idx++;
            @(negedge clk);
            budget++;
            if (budget > 4000) begin
                check("byte_feed_timeout", idx, bytes.size());
                break;
            end
        end
        in_valid_i = 1'b0;
        start_i    = 1'b0;
        for (int t = 0; t < 20 && !(done_o | error_o); t++) @(negedge clk);
        check("session_end_seen", {31'd0, done_o | error_o}, 32'd1);
        @(negedge clk);
        latency = int'(done_cyc - s);
    endtask

    int lat;

    initial begin
        reset_i = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_in_ready", {31'd0, in_ready_o}, 32'd0);
        check("rst_mem_wr", {31'd0, mem_wr_o}, 32'd0);
        check("rst_mem_addr", {25'd0, mem_addr_o}, 32'd0);
        check("rst_mem_data", {16'd0, mem_data_o}, 32'd0);
        check("rst_busy", {31'd0, busy_o}, 32'd0);
        check("rst_done", {31'd0, done_o}, 32'd0);
        check("rst_error", {31'd0, error_o}, 32'd0);
        check("rst_word_count", {24'd0, word_count_o}, 32'd0);
        check("rst_proc_reset", {31'd0, proc_reset_o}, 32'd1);
        reset_i = 1'b0;
        @(negedge clk);

        fixed_q.push_back(16'h2105);
        fixed_q.push_back(16'h5000);
        run_session(2, 0, 1'b0, 1'b0, lat);
`ifdef LOADER_CHECKSUM_EN
        check("latency_n2", lat, 32'd9);
`else
        check("latency_n2", lat, 32'd8);
`endif

        run_session(0, 0, 1'b0, 1'b0, lat);
        run_session(129, 0, 1'b0, 1'b0, lat);
        run_session(256, 2, 1'b0, 1'b0, lat);

        fixed_q.push_back(16'h3012);
        run_session(1, 1, 1'b0, 1'b0, lat);

        // Reset after the first of three words has been written.
        exp_wr.push_back('{7'd0, 16'hA55A});
        @(negedge clk);
        start_i = 1'b1;
        @(negedge clk);
        start_i    = 1'b0;
        in_valid_i = 1'b1;
        in_data_i  = 8'h00; @(negedge clk);
        in_data_i  = 8'h03; @(negedge clk);
        in_data_i  = 8'hA5; @(negedge clk);
        in_data_i  = 8'h5A; @(negedge clk);
        in_valid_i = 1'b0;
        for (int t = 0; t < 10 && !mem_wr_o; t++) @(negedge clk);
        reset_i = 1'b1;
        @(negedge clk);
        reset_i = 1'b0;
        check("midrst_busy", {31'd0, busy_o}, 32'd0);
        check("midrst_in_ready", {31'd0, in_ready_o}, 32'd0);
        check("midrst_word_count", {24'd0, word_count_o}, 32'd0);
        check("midrst_proc_reset", {31'd0, proc_reset_o}, 32'd1);
        check("midrst_pending_writes", exp_wr.size(), 32'd0);
        run_session(3, 0, 1'b0, 1'b0, lat);

        run_session(4, 2, 1'b1, 1'b0, lat);
        run_session(1, 0, 1'b0, 1'b0, lat);

`ifdef LOADER_CHECKSUM_EN
        fixed_q.push_back(16'h3012);
        run_session(1, 0, 1'b0, 1'b0, lat);
        fixed_q.push_back(16'h3012);
        run_session(1, 0, 1'b0, 1'b1, lat);
        run_session(5, 2, 1'b0, 1'b1, lat);
`endif

        for (int k = 0; k < 8; k++) begin
            run_session($urandom_range(0, 140), 2, 1'b0, 1'($urandom_range(0, 1)), lat);
        end
        run_session(128, 0, 1'b0, 1'b0, lat);
        run_session(128, 2, 1'b0, 1'b0, lat);

        repeat (2) @(negedge clk);
        check("final_pending_writes", exp_wr.size(), 32'd0);
        check("final_pending_results", exp_res.size(), 32'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
